// File: rtl/gpio_seq_pkg.sv
// Shared state encoding and default sizing for the GPIO sequence responder.
package gpio_seq_pkg;

    localparam int NSTEPS_DEF = 8;
    localparam int DLY_W_DEF  = 16;
    localparam int TMO_W_DEF  = 20;
    localparam int GPIO_W     = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_MATCH,
        S_DELAY,
        S_DRIVE,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/gpio_sync2.sv
// Two-flop synchronizer bringing the asynchronous gpio pattern into clk.
module gpio_sync2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gpio_seq_responder.sv
// Table-driven GPIO responder: wait for a stable pattern on gpio[15:8],
// delay, then drive the programmed response on gpio[7:0], step by step.
module gpio_seq_responder
    import gpio_seq_pkg::*;
#(
    parameter int NSTEPS = NSTEPS_DEF,
    parameter int DLY_W  = DLY_W_DEF,
    parameter int TMO_W  = TMO_W_DEF
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      enable,
    input  logic [GPIO_W-1:0]         gpio_hi_in,
    output logic [GPIO_W-1:0]         gpio_lo_out,
    output logic                      gpio_lo_oe,
    input  logic                      cfg_we,
    input  logic [$clog2(NSTEPS)-1:0] cfg_addr,
    input  logic [GPIO_W-1:0]         cfg_match,
    input  logic [GPIO_W-1:0]         cfg_drive,
    input  logic [DLY_W-1:0]          cfg_delay,
    input  logic [$clog2(NSTEPS):0]   cfg_nsteps,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout_err,
    output logic [$clog2(NSTEPS)-1:0] step_idx
);

    localparam int IW = $clog2(NSTEPS);
    localparam int NW = IW + 1;

    state_t            state, state_n;
    logic [GPIO_W-1:0] hi_s;
    logic              en_q;
    logic              start;
    logic              hit, hit_q, qualified;
    logic              last;
    logic [NW-1:0]     nsteps_r, nsteps_lim;
    logic [IW-1:0]     idx;
    logic [DLY_W-1:0]  dly_cnt;
    logic [TMO_W-1:0]  tmo_cnt, tmo_next;

    logic [GPIO_W-1:0] match_tab [NSTEPS];
    logic [GPIO_W-1:0] drive_tab [NSTEPS];
    logic [DLY_W-1:0]  delay_tab [NSTEPS];

    gpio_sync2 #(.W(GPIO_W)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (gpio_hi_in),
        .q      (hi_s)
    );

    assign start      = enable & ~en_q;
    assign hit        = (hi_s == match_tab[idx]);
    assign qualified  = hit & hit_q;
    assign tmo_next   = tmo_cnt + TMO_W'(1);
    assign last       = (NW'(idx) + NW'(1)) == nsteps_r;
    assign nsteps_lim = (cfg_nsteps > NW'(NSTEPS)) ? NW'(NSTEPS) : cfg_nsteps;

    assign busy        = (state == S_WAIT_MATCH) || (state == S_DELAY) || (state == S_DRIVE);
    assign done        = (state == S_DONE);
    assign timeout_err = (state == S_ERR);
    assign step_idx    = idx;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_n = (cfg_nsteps == '0) ? S_DONE : S_WAIT_MATCH;
            end
            S_WAIT_MATCH: begin
                if (!enable)        state_n = S_IDLE;
                else if (qualified) state_n = (delay_tab[idx] == '0) ? S_DRIVE : S_DELAY;
                else if (&tmo_next) state_n = S_ERR;
            end
            S_DELAY: begin
                // Counter holds the remaining DELAY cycles, so 1 means this is the last
                if (!enable)                       state_n = S_IDLE;
                else if (dly_cnt <= DLY_W'(1))     state_n = S_DRIVE;
            end
            S_DRIVE: begin
                if (!enable)   state_n = S_IDLE;
                else if (last) state_n = S_DONE;
                else           state_n = S_WAIT_MATCH;
            end
            S_DONE, S_ERR: begin
                if (!enable) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // en_q resets high so an enable held across reset needs a fresh rise
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en_q     <= 1'b1;
            hit_q    <= 1'b0;
            nsteps_r <= '0;
            idx      <= '0;
            dly_cnt  <= '0;
            tmo_cnt  <= '0;
        end else begin
            en_q  <= enable;
            hit_q <= (state == S_WAIT_MATCH && state_n == S_WAIT_MATCH) ? hit : 1'b0;

            if (state == S_IDLE && start) nsteps_r <= nsteps_lim;

            if (state_n == S_IDLE || state == S_IDLE) idx <= '0;
            else if (state == S_DRIVE)                idx <= idx + IW'(1);

            if (state == S_WAIT_MATCH && qualified)    dly_cnt <= delay_tab[idx];
            else if (state == S_DELAY && dly_cnt != '0) dly_cnt <= dly_cnt - DLY_W'(1);
            else if (state != S_DELAY)                 dly_cnt <= '0;

            tmo_cnt <= (state == S_WAIT_MATCH && state_n == S_WAIT_MATCH) ? tmo_next : '0;
        end
    end

    // Output is captured on DRIVE entry so it is visible during the DRIVE cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gpio_lo_out <= '0;
            gpio_lo_oe  <= 1'b0;
        end else if (state_n == S_DRIVE) begin
            gpio_lo_out <= drive_tab[idx];
            gpio_lo_oe  <= 1'b1;
        end else if (state_n == S_IDLE && state != S_IDLE) begin
            gpio_lo_oe  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NSTEPS; i++) begin
                match_tab[i] <= '0;
                drive_tab[i] <= '0;
                delay_tab[i] <= '0;
            end
        end else if (cfg_we && !busy) begin
            match_tab[cfg_addr] <= cfg_match;
            drive_tab[cfg_addr] <= cfg_drive;
            delay_tab[cfg_addr] <= cfg_delay;
        end
    end

endmodule

// File: doc/gpio_seq_responder.md
GPIO_SEQ_RESPONDER -- requirements
Module: gpio_seq_responder

Interface
REQ-001 SHALL have parameter NSTEPS, default 8, meaning number of sequence table entries (power of two, 2..16).
REQ-002 SHALL have parameter DLY_W, default 16, meaning width of the per-step delay counter.
REQ-003 SHALL have parameter TMO_W, default 20, meaning width of the match-timeout counter.
REQ-004 SHALL have ports: clk  in  1  single system clock.
REQ-005 SHALL have ports: resetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: enable  in  1  run sequence; deassertion aborts.
REQ-007 SHALL have ports: gpio_hi_in  in  8  pattern from SoC gpio[15:8], asynchronous.
REQ-008 SHALL have ports: gpio_lo_out  out  8  response value for gpio[7:0].
REQ-009 SHALL have ports: gpio_lo_oe  out  1  drive enable for gpio_lo_out; 0 = high-Z.
REQ-010 SHALL have ports: cfg_we  in  1, cfg_addr  in  log2(NSTEPS), cfg_match  in  8, cfg_drive  in  8, cfg_delay  in  DLY_W  table write port.
REQ-011 SHALL have ports: cfg_nsteps  in  log2(NSTEPS)+1  active step count, sampled on enable rise.
REQ-012 SHALL have ports: busy  out  1, done  out  1, timeout_err  out  1, step_idx  out  log2(NSTEPS)  status.

Function
REQ-013 SHALL pass gpio_hi_in through a two-flop synchronizer before any comparison.
REQ-014 SHALL implement states IDLE, WAIT_MATCH, DELAY, DRIVE, DONE, ERR.
REQ-015 IDLE -> WAIT_MATCH on enable rising edge with cfg_nsteps>0; with cfg_nsteps==0 -> DONE directly.
REQ-016 WAIT_MATCH SHALL qualify a match only when synchronized gpio_hi equals match[step_idx] on two consecutive clk cycles.
REQ-017 On a qualified match SHALL load delay[step_idx] into the down-counter and enter DELAY.
REQ-018 DELAY SHALL decrement each cycle; at zero SHALL enter DRIVE (delay 0 gives DRIVE the cycle after qualification).
REQ-019 DRIVE SHALL last one cycle: register gpio_lo_out=drive[step_idx], set gpio_lo_oe=1, increment step_idx; the last active step -> DONE, otherwise -> WAIT_MATCH.
REQ-020 gpio_lo_out/gpio_lo_oe SHALL hold the last driven value across subsequent steps and in DONE.
REQ-021 A timeout counter SHALL clear on WAIT_MATCH entry and increment each WAIT_MATCH cycle; reaching all-ones -> ERR with timeout_err=1.
REQ-022 busy SHALL be 1 in WAIT_MATCH, DELAY and DRIVE only; done SHALL be 1 only in DONE.
REQ-023 DONE and ERR SHALL persist until enable deasserts, then -> IDLE clearing done, timeout_err and step_idx.
REQ-024 enable deassertion in any busy state SHALL abort to IDLE next cycle with gpio_lo_oe=0.
REQ-025 cfg_we SHALL write the table entry at cfg_addr when not busy; writes while busy SHALL be ignored.
REQ-026 A match value equal to the current gpio_hi at WAIT_MATCH entry SHALL qualify normally (no edge required).

Reset
REQ-027 resetn low SHALL asynchronously force IDLE, gpio_lo_out=0, gpio_lo_oe=0, busy=0, done=0, timeout_err=0, step_idx=0, counters=0, synchronizer=0.
REQ-028 Table contents SHALL reset to all zeros; reset mid-sequence SHALL require a new enable rise to restart.

Structure
REQ-029 State encoding and default parameter constants SHALL live in shared package gpio_seq_pkg.
REQ-030 The two-flop synchronizer SHALL be sub-module gpio_sync2 (8-bit instance).

Verification
REQ-031 Table {A0->F0,0B->0F,AB->00,01->01,02->03}, delays 0, nsteps=5; drive hi A0,0B,AB,01,02 -> lo sequence F0,0F,00,01,03, done=1.
REQ-032 Step 0 delay 1000, hi=A0 -> gpio_lo_out=F0 exactly 1000+1 clk after match qualification.
REQ-033 hi glitches to A0 for one cycle only -> no match, lo_oe stays 0.
REQ-034 TMO_W=8, hi never matches -> timeout_err=1 after 255 WAIT_MATCH cycles, busy=0.
REQ-035 enable dropped in DELAY of step 2 -> IDLE, lo_oe=0; re-enable restarts at step 0.
REQ-036 resetn asserted mid-DELAY -> all outputs 0 immediately, table cleared.
